// File: rtl/load_store_unit_if.sv
// Request, data-memory and response signals of the load/store unit.
// The unit connects through the slave modport; the EX stage / memory model uses master.
interface load_store_unit_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_write;
    logic [2:0]            req_funct3;
    logic [DATA_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  req_ready;
    logic                  stall;

    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [3:0]            mem_be;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_misaligned;
    logic                  rsp_buserr;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output req_ready, stall,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata,
        output rsp_valid, rsp_rdata, rsp_misaligned, rsp_buserr
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready, stall,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata,
        input  rsp_valid, rsp_rdata, rsp_misaligned, rsp_buserr
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: IDLE/BUSY/DONE FSM issuing one data-memory access per request,
// with alignment checking, byte-lane steering, load extension and a BUSY-cycle timeout.
module load_store_unit #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    load_store_unit_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    // Counter value of the last BUSY cycle allowed before declaring a bus error.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                r_state;
    logic [7:0]            r_cnt;
    logic [1:0]            r_lane;
    logic [2:0]            r_funct3;
    logic                  r_write;

    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [DATA_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [3:0]            r_mem_be;

    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_misaligned;
    logic                  r_rsp_buserr;

    logic                  w_illegal;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_load;

    // Request decode, evaluated on the live request inputs at the accept edge.
    always_comb begin
        w_illegal = 1'b0;
        w_be      = 4'b0000;
        w_wdata   = bus.req_wdata;
        case (bus.req_funct3)
            3'b000, 3'b100: begin
                w_illegal = bus.req_write & bus.req_funct3[2];
                w_be      = 4'b0001 << bus.req_addr[1:0];
                w_wdata   = {(DATA_WIDTH/8){bus.req_wdata[7:0]}};
            end
            3'b001, 3'b101: begin
                w_illegal = bus.req_addr[0] | (bus.req_write & bus.req_funct3[2]);
                w_be      = 4'b0011 << bus.req_addr[1:0];
                w_wdata   = {(DATA_WIDTH/16){bus.req_wdata[15:0]}};
            end
            3'b010: begin
                w_illegal = (bus.req_addr[1:0] != 2'b00);
                w_be      = 4'b1111;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Load result extraction from the latched lane and width code.
    always_comb begin
        w_byte = 8'h00;
        case (r_lane)
            2'd0: w_byte = bus.mem_rdata[7:0];
            2'd1: w_byte = bus.mem_rdata[15:8];
            2'd2: w_byte = bus.mem_rdata[23:16];
            2'd3: w_byte = bus.mem_rdata[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = r_lane[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            3'b100:  w_load = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            3'b001:  w_load = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            3'b101:  w_load = {{(DATA_WIDTH-16){1'b0}}, w_half};
            default: w_load = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_cnt            <= '0;
            r_lane           <= '0;
            r_funct3         <= '0;
            r_write          <= 1'b0;
            r_mem_req        <= 1'b0;
            r_mem_we         <= 1'b0;
            r_mem_addr       <= '0;
            r_mem_wdata      <= '0;
            r_mem_be         <= '0;
            r_rsp_valid      <= 1'b0;
            r_rsp_rdata      <= '0;
            r_rsp_misaligned <= 1'b0;
            r_rsp_buserr     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_lane      <= bus.req_addr[1:0];
                        r_funct3    <= bus.req_funct3;
                        r_write     <= bus.req_write;
                        r_mem_addr  <= {bus.req_addr[DATA_WIDTH-1:2], 2'b00};
                        r_mem_wdata <= w_wdata;
                        r_mem_be    <= w_be;
                        r_cnt       <= '0;
                        if (w_illegal) begin
                            r_state          <= S_DONE;
                            r_rsp_valid      <= 1'b1;
                            r_rsp_rdata      <= '0;
                            r_rsp_misaligned <= 1'b1;
                        end else begin
                            r_state   <= S_BUSY;
                            r_mem_req <= 1'b1;
                            r_mem_we  <= bus.req_write;
                        end
                    end
                end
                S_BUSY: begin
                    // Ack is tested first so an ack on the final allowed cycle wins.
                    if (bus.mem_ack) begin
                        r_state     <= S_DONE;
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_write ? '0 : w_load;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        r_state      <= S_DONE;
                        r_mem_req    <= 1'b0;
                        r_mem_we     <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_rdata  <= '0;
                        r_rsp_buserr <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    r_state          <= S_IDLE;
                    r_rsp_valid      <= 1'b0;
                    r_rsp_rdata      <= '0;
                    r_rsp_misaligned <= 1'b0;
                    r_rsp_buserr     <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready      = (r_state == S_IDLE);
    assign bus.stall          = ((r_state == S_IDLE) && bus.req_valid) || (r_state == S_BUSY);
    assign bus.mem_req        = r_mem_req;
    assign bus.mem_we         = r_mem_we;
    assign bus.mem_addr       = r_mem_addr;
    assign bus.mem_wdata      = r_mem_wdata;
    assign bus.mem_be         = r_mem_be;
    assign bus.rsp_valid      = r_rsp_valid;
    assign bus.rsp_rdata      = r_rsp_rdata;
    assign bus.rsp_misaligned = r_rsp_misaligned;
    assign bus.rsp_buserr     = r_rsp_buserr;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (TIMEOUT_CYCLES = 4).
// Inputs change 1 ns after the rising edge; outputs are sampled at that same point.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if #(.DATA_WIDTH(32)) bus ();

    load_store_unit #(
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    typedef struct packed {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_mwdata;
    } vec_t;

    vec_t legal_tab [10] = '{
        '{1'b0, 3'b000, 32'h0000_0000, 32'h0, 32'h80FF_1234, 32'h0000_0034, 4'b0001, 32'h0},
        '{1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 32'hFFFF_FF80, 4'b1000, 32'h0},
        '{1'b0, 3'b100, 32'h0000_0102, 32'h0, 32'h80FF_1234, 32'h0000_00FF, 4'b0100, 32'h0},
        '{1'b0, 3'b001, 32'h0000_0002, 32'h0, 32'h80FF_1234, 32'hFFFF_80FF, 4'b1100, 32'h0},
        '{1'b0, 3'b101, 32'h0000_0002, 32'h0, 32'h80FF_1234, 32'h0000_80FF, 4'b1100, 32'h0},
        '{1'b0, 3'b001, 32'h0000_0000, 32'h0, 32'h80FF_1234, 32'h0000_1234, 4'b0011, 32'h0},
        '{1'b0, 3'b010, 32'h0000_0004, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b1111, 32'h0},
        '{1'b1, 3'b000, 32'h0000_0001, 32'h1234_56A5, 32'hDEAD_BEEF, 32'h0, 4'b0010, 32'hA5A5_A5A5},
        '{1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'hDEAD_BEEF, 32'h0, 4'b1100, 32'hABCD_ABCD},
        '{1'b1, 3'b010, 32'h0000_0008, 32'h1122_3344, 32'hDEAD_BEEF, 32'h0, 4'b1111, 32'h1122_3344}
    };

    vec_t illegal_tab [9] = '{
        '{1'b0, 3'b010, 32'h0000_0001, 32'h0, 32'h0, 32'h0, 4'b0, 32'h0},
        '{1'b0, 3'b001, 32'h0000_0003, 32'h0, 32'h0, 32'h0, 4'b0, 32'h0},
        '{1'b0, 3'b101, 32'h0000_0001, 32'h0, 32'h0, 32'h0, 4'b0, 32'h0},
        '{1'b0, 3'b011, 32'h0000_0000, 32'h0, 32'h0, 32'h0, 4'b0, 32'h0},
        '{1'b0, 3'b110, 32'h0000_0000, 32'h0, 32'h0, 32'h0, 4'b0, 32'h0},
        '{1'b0, 3'b111, 32'h0000_0000, 32'h0, 32'h0, 32'h0, 4'b0, 32'h0},
        '{1'b1, 3'b100, 32'h0000_0000, 32'h5, 32'h0, 32'h0, 4'b0, 32'h0},
        '{1'b1, 3'b101, 32'h0000_0000, 32'h5, 32'h0, 32'h0, 4'b0, 32'h0},
        '{1'b1, 3'b010, 32'h0000_0002, 32'h5, 32'h0, 32'h0, 4'b0, 32'h0}
    };

    // Runs one request with a zero-wait ack and reports what the unit produced.
    // Request inputs are scrambled after the accept edge to expose any use of live inputs.
    task automatic run_op(input vec_t v,
                          output logic [31:0] o_rdata, output logic [3:0] o_be,
                          output logic [31:0] o_maddr, output logic [31:0] o_mwdata,
                          output logic o_mwe, output logic o_mis, output logic o_berr,
                          output logic o_req_seen, output logic o_valid_after,
                          output int unsigned o_lat);
        o_rdata = 'x; o_be = '0; o_maddr = '0; o_mwdata = '0; o_mwe = 1'b0;
        o_mis = 1'bx; o_berr = 1'bx; o_req_seen = 1'b0; o_lat = 99;
        bus.req_valid  = 1'b1;
        bus.req_write  = v.wr;
        bus.req_funct3 = v.f3;
        bus.req_addr   = v.addr;
        bus.req_wdata  = v.wdata;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            bus.mem_ack = 1'b0;
            if (i == 0) begin
                bus.req_valid  = 1'b0;
                bus.req_write  = ~v.wr;
                bus.req_funct3 = 3'b010;
                bus.req_addr   = ~v.addr;
                bus.req_wdata  = ~v.wdata;
            end
            if (bus.rsp_valid) begin
                o_rdata = bus.rsp_rdata;
                o_mis   = bus.rsp_misaligned;
                o_berr  = bus.rsp_buserr;
                o_lat   = i + 1;
                break;
            end
            if (bus.mem_req) begin
                o_req_seen    = 1'b1;
                o_be          = bus.mem_be;
                o_maddr       = bus.mem_addr;
                o_mwdata      = bus.mem_wdata;
                o_mwe         = bus.mem_we;
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = v.rdata;
            end
        end
        @(posedge clk);
        #1;
        o_valid_after = bus.rsp_valid;
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = '0; bus.req_wdata = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.rsp_valid, bus.rsp_misaligned,
             bus.rsp_buserr, bus.stall, bus.req_ready} !== 11'b0_0_0000_0_0_0_0_1)
            $display("FAIL reset_ctrl: got %b expected 00000000001",
                     {bus.mem_req, bus.mem_we, bus.mem_be, bus.rsp_valid, bus.rsp_misaligned,
                      bus.rsp_buserr, bus.stall, bus.req_ready});
        else n_pass++;
        n_total++;
        if ({bus.mem_addr, bus.mem_wdata, bus.rsp_rdata} !== 96'h0)
            $display("FAIL reset_data: got %h expected 0", {bus.mem_addr, bus.mem_wdata, bus.rsp_rdata});
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_ack_ignored_idle();
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h1111_1111;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        n_total++;
        if ({bus.rsp_valid, bus.req_ready, bus.mem_req} !== 3'b010)
            $display("FAIL idle_ack: got %b expected 010", {bus.rsp_valid, bus.req_ready, bus.mem_req});
        else n_pass++;
    endtask

    task automatic test_lb_waited();
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h0000_0103; bus.req_wdata = '0;
        #1;
        n_total++;
        if ({bus.stall, bus.req_ready} !== 2'b11)
            $display("FAIL lb_idle_stall: got %b expected 11", {bus.stall, bus.req_ready});
        else n_pass++;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'hFFFF_FFFF;
        n_total++;
        if ({bus.mem_req, bus.mem_we, bus.stall, bus.req_ready} !== 4'b1010)
            $display("FAIL lb_busy_ctrl: got %b expected 1010", {bus.mem_req, bus.mem_we, bus.stall, bus.req_ready});
        else n_pass++;
        n_total++;
        if (bus.mem_addr !== 32'h0000_0100)
            $display("FAIL lb_mem_addr: got %h expected 00000100", bus.mem_addr);
        else n_pass++;
        n_total++;
        if (bus.mem_be !== 4'b1000)
            $display("FAIL lb_mem_be: got %b expected 1000", bus.mem_be);
        else n_pass++;
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h80FF_1234;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        bus.req_valid = 1'b1;
        #1;
        n_total++;
        if ({bus.rsp_valid, bus.rsp_misaligned, bus.rsp_buserr, bus.mem_req, bus.stall, bus.req_ready} !== 6'b100000)
            $display("FAIL lb_done_ctrl: got %b expected 100000",
                     {bus.rsp_valid, bus.rsp_misaligned, bus.rsp_buserr, bus.mem_req, bus.stall, bus.req_ready});
        else n_pass++;
        n_total++;
        if (bus.rsp_rdata !== 32'hFFFF_FF80)
            $display("FAIL lb_rsp_rdata: got %h expected ffffff80", bus.rsp_rdata);
        else n_pass++;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if ({bus.rsp_valid, bus.req_ready, bus.rsp_rdata} !== {2'b01, 32'h0})
            $display("FAIL lb_after: got %b %h expected 01 00000000", {bus.rsp_valid, bus.req_ready}, bus.rsp_rdata);
        else n_pass++;
    endtask

    task automatic test_legal_ops();
        logic [31:0] rd, ma, mw;
        logic [3:0] be;
        logic we, mis, berr, seen, va;
        int unsigned lat;
        for (int i = 0; i < 10; i++) begin
            run_op(legal_tab[i], rd, be, ma, mw, we, mis, berr, seen, va, lat);
            n_total++;
            if ({seen, we, be} !== {1'b1, legal_tab[i].wr, legal_tab[i].exp_be})
                $display("FAIL op%0d_mem_ctrl: got %b expected %b", i, {seen, we, be},
                         {1'b1, legal_tab[i].wr, legal_tab[i].exp_be});
            else n_pass++;
            n_total++;
            if (ma !== {legal_tab[i].addr[31:2], 2'b00})
                $display("FAIL op%0d_mem_addr: got %h expected %h", i, ma, {legal_tab[i].addr[31:2], 2'b00});
            else n_pass++;
            if (legal_tab[i].wr) begin
                n_total++;
                if (mw !== legal_tab[i].exp_mwdata)
                    $display("FAIL op%0d_mem_wdata: got %h expected %h", i, mw, legal_tab[i].exp_mwdata);
                else n_pass++;
            end
            n_total++;
            if (rd !== legal_tab[i].exp_rdata)
                $display("FAIL op%0d_rsp_rdata: got %h expected %h", i, rd, legal_tab[i].exp_rdata);
            else n_pass++;
            n_total++;
            if ({mis, berr, va, lat} !== {3'b000, 32'd2})
                $display("FAIL op%0d_rsp_flags_lat: got %b lat %0d expected 000 lat 2", i, {mis, berr, va}, lat);
            else n_pass++;
        end
    endtask

    task automatic test_illegal_ops();
        logic [31:0] rd, ma, mw;
        logic [3:0] be;
        logic we, mis, berr, seen, va;
        int unsigned lat;
        for (int i = 0; i < 9; i++) begin
            run_op(illegal_tab[i], rd, be, ma, mw, we, mis, berr, seen, va, lat);
            n_total++;
            if ({seen, mis, berr, va} !== 4'b0100)
                $display("FAIL ill%0d_flags: got %b expected 0100", i, {seen, mis, berr, va});
            else n_pass++;
            n_total++;
            if ({rd, lat} !== {32'h0, 32'd1})
                $display("FAIL ill%0d_rdata_lat: got %h lat %0d expected 00000000 lat 1", i, rd, lat);
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        int unsigned busy;
        logic got;
        for (int pass = 0; pass < 2; pass++) begin
            busy = 0;
            got  = 1'b0;
            bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_funct3 = 3'b101;
            bus.req_addr = 32'h0000_0000;
            for (int i = 0; i < 12; i++) begin
                @(posedge clk); #1;
                bus.mem_ack = 1'b0;
                if (i == 0) bus.req_valid = 1'b0;
                if (bus.rsp_valid) begin
                    got = 1'b1;
                    break;
                end
                if (bus.mem_req) busy++;
                if (pass == 1 && busy == 4) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = 32'h1234_8765;
                end
            end
            n_total++;
            if ({got, busy} !== {1'b1, 32'd4})
                $display("FAIL tmo%0d_busy_cycles: got rsp %b busy %0d expected rsp 1 busy 4", pass, got, busy);
            else n_pass++;
            n_total++;
            if ({bus.rsp_buserr, bus.rsp_misaligned} !== {pass == 0, 1'b0})
                $display("FAIL tmo%0d_flags: got %b expected %b", pass,
                         {bus.rsp_buserr, bus.rsp_misaligned}, {pass == 0, 1'b0});
            else n_pass++;
            n_total++;
            if (bus.rsp_rdata !== ((pass == 0) ? 32'h0 : 32'h0000_8765))
                $display("FAIL tmo%0d_rdata: got %h expected %h", pass, bus.rsp_rdata,
                         (pass == 0) ? 32'h0 : 32'h0000_8765);
            else n_pass++;
            @(posedge clk); #1;
            n_total++;
            if ({bus.rsp_valid, bus.rsp_buserr} !== 2'b00)
                $display("FAIL tmo%0d_after: got %b expected 00", pass, {bus.rsp_valid, bus.rsp_buserr});
            else n_pass++;
        end
    endtask

    task automatic test_reset_busy();
        logic seen_valid = 1'b0;
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h0000_0010;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n_total++;
        if (bus.mem_req !== 1'b1)
            $display("FAIL rstb_busy: got mem_req %b expected 1", bus.mem_req);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({bus.mem_req, bus.rsp_valid, bus.req_ready, bus.stall} !== 4'b0010)
            $display("FAIL rstb_async: got %b expected 0010", {bus.mem_req, bus.rsp_valid, bus.req_ready, bus.stall});
        else n_pass++;
        @(posedge clk); #1;
        seen_valid |= bus.rsp_valid;
        @(negedge clk);
        seen_valid |= bus.rsp_valid;
        rst_n = 1'b1;
        bus.req_valid = 1'b1; bus.req_funct3 = 3'b000; bus.req_addr = 32'h0000_0000;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        seen_valid |= bus.rsp_valid;
        n_total++;
        if ({bus.mem_req, bus.mem_be, seen_valid} !== 6'b1_0001_0)
            $display("FAIL rstb_reaccept: got %b expected 100010", {bus.mem_req, bus.mem_be, seen_valid});
        else n_pass++;
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h0000_00FF;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        n_total++;
        if ({bus.rsp_valid, bus.rsp_rdata} !== {1'b1, 32'hFFFF_FFFF})
            $display("FAIL rstb_rsp: got %b %h expected 1 ffffffff", bus.rsp_valid, bus.rsp_rdata);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_ack_ignored_idle();
        test_lb_waited();
        test_legal_ops();
        test_illegal_ops();
        test_timeout();
        test_reset_busy();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1);
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the width of address and data paths.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum number of BUSY cycles without mem_ack before a bus error (range 1..255).
REQ-003 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-low.
REQ-004 The block SHALL provide these ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  EX stage presents a memory operation
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  effective address (ALU result)
- req_wdata  in  32  store data (rs2)
- req_ready  out  1  unit can accept a request
- stall  out  1  hold upstream pipeline stages
- mem_req  out  1  data-memory request
- mem_we  out  1  data-memory write enable
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte-lane enables
- mem_ack  in  1  memory completed the access this cycle
- mem_rdata  in  32  memory read word, valid when mem_ack=1
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load result; 0 for stores and errors
- rsp_misaligned  out  1  with rsp_valid: misaligned or illegal funct3
- rsp_buserr  out  1  with rsp_valid: timeout

Function
REQ-005 The FSM SHALL have states IDLE, BUSY and DONE; req_ready=1 only in IDLE.
REQ-006 A request SHALL be accepted on a rising edge with state=IDLE and req_valid=1; req_addr, req_funct3, req_write and req_wdata SHALL be latched at that edge and used until the next return to IDLE, ignoring later changes on the inputs.
REQ-007 The block SHALL treat an accepted request as illegal if: W with addr[1:0]!=0; H/HU with addr[0]=1; funct3 in {011,110,111}; or a store with funct3 in {100,101}.
REQ-008 An illegal request SHALL go IDLE->DONE without asserting mem_req and SHALL set rsp_misaligned=1 and rsp_rdata=0.
REQ-009 A legal request SHALL go IDLE->BUSY; in BUSY, mem_req SHALL be 1 and mem_we, mem_addr, mem_be and mem_wdata SHALL be driven from the latched request.
REQ-010 mem_be SHALL be 4'b0001<<addr[1:0] for B/BU, 4'b0011<<addr[1:0] for H/HU and 4'b1111 for W, for both loads and stores.
REQ-011 mem_wdata SHALL be {4{wdata[7:0]}} for SB, {2{wdata[15:0]}} for SH and wdata for SW.
REQ-012 BUSY with mem_ack=1 SHALL go to DONE and capture the load result: selected byte or halfword lane by addr[1:0], sign-extended for B/H and zero-extended for BU/HU; full word for W.
REQ-013 A BUSY cycle counter SHALL start at 0 on BUSY entry and increment each BUSY cycle without mem_ack.
REQ-014 When the counter reaches TIMEOUT_CYCLES without mem_ack, the block SHALL go to DONE with rsp_buserr=1 and rsp_rdata=0.
REQ-015 If mem_ack=1 in the same cycle the timeout limit is reached, the ack SHALL win and no bus error SHALL be raised.
REQ-016 In DONE, rsp_valid SHALL be 1 for exactly one cycle with rsp_rdata/rsp_misaligned/rsp_buserr valid; the next state SHALL be IDLE unconditionally.
REQ-017 rsp_misaligned and rsp_buserr SHALL be 0 whenever rsp_valid=0.
REQ-018 stall SHALL be (IDLE & req_valid) | BUSY, and SHALL be 0 in DONE so the pipeline advances with the response.
REQ-019 mem_ack in IDLE or DONE SHALL be ignored.
REQ-020 Latency SHALL be: accept edge N, mem_req high from cycle N+1, rsp_valid one cycle after the ack cycle; a zero-wait ack gives rsp_valid in N+2.

Reset
REQ-021 rst_n=0 SHALL immediately force IDLE, clear the counter and latched request, and drive mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_misaligned=0, rsp_buserr=0, stall=0 and req_ready=1.
REQ-022 Reset during BUSY or DONE SHALL abort the operation with no rsp_valid pulse; after release, the unit SHALL accept a new request on the first edge.

Verification
REQ-023 The bench SHALL cover: LB at addr 0x103 with mem_rdata=0x80FF_1234 and ack one cycle later -> mem_addr=0x100, mem_be=1000, rsp_rdata=0xFFFF_FF80.
REQ-024 The bench SHALL cover: SH at 0x202 with wdata=0x1234_ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCD_ABCD, rsp_rdata=0.
REQ-025 The bench SHALL cover: LW at 0x001 -> mem_req never 1, rsp_valid at N+1 with rsp_misaligned=1.
REQ-026 The bench SHALL cover: LHU at 0x000 with no ack and TIMEOUT_CYCLES=4 -> mem_req high 4 cycles, then rsp_buserr=1; a repeat with ack on the 4th BUSY cycle -> no error.
REQ-027 The bench SHALL cover: rst_n low for one cycle while in BUSY -> mem_req drops asynchronously, no rsp_valid, req_ready=1 after release.
